// File: rtl/match_stat_counter.sv
// Per-lane match/pass/filter event counters feeding the MMIO statistics words.
// Three stages: lane capture, popcount, accumulate. Define MATCH_STAT_SATURATE_EN to clamp instead of wrap.
module match_stat_counter #(
  parameter int unsigned          LANES     = 4,
  parameter int unsigned          CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] RST_COUNT = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_valid,
  input  logic [LANES-1:0]     i_match_vec,
  input  logic [LANES-1:0]     i_pass_vec,
  input  logic [LANES-1:0]     i_filter_vec,
  input  logic                 i_counter_reset,
  output logic [CNT_WIDTH-1:0] o_match_count,
  output logic [CNT_WIDTH-1:0] o_pass_count,
  output logic [CNT_WIDTH-1:0] o_filter_count,
  output logic [2:0]           o_ovf,
  output logic                 o_clearing
);

  localparam int unsigned PCW  = $clog2(LANES + 1);
  localparam int unsigned NCLS = 3;

  // Class index: 0 = match, 1 = pass, 2 = filter (same order as o_ovf).
  logic [NCLS-1:0][LANES-1:0]     vec;
  logic [NCLS-1:0][LANES-1:0]     cap;
  logic [NCLS-1:0][PCW-1:0]       pc_next;
  logic [NCLS-1:0][PCW-1:0]       pc;
  logic [NCLS-1:0][CNT_WIDTH:0]   sum;
  logic [NCLS-1:0][CNT_WIDTH-1:0] cnt;
  logic                           clr_q;
  logic                           clr_d1;

  assign vec = {i_filter_vec, i_pass_vec, i_match_vec};

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    pc_next = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NCLS; k++) begin
      pc_next[k] = popcount(cap[k]);
      sum[k]     = {1'b0, cnt[k]} + (CNT_WIDTH + 1)'(pc[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cap        <= '0;
      pc         <= '0;
      cnt        <= {NCLS{RST_COUNT}};
      o_ovf      <= '0;
      clr_q      <= 1'b0;
      clr_d1     <= 1'b0;
      o_clearing <= 1'b0;
    end else begin
      // Clearing flag covers the clear cycle plus two cycles while S1/S2 drain.
      clr_q      <= i_counter_reset;
      clr_d1     <= clr_q;
      o_clearing <= i_counter_reset | clr_q | clr_d1;
      if (i_counter_reset) begin
        cap   <= '0;
        pc    <= '0;
        cnt   <= '0;
        o_ovf <= '0;
      end else begin
        cap <= i_valid ? vec : '0;
        pc  <= pc_next;
        for (int unsigned k = 0; k < NCLS; k++) begin
          if (sum[k][CNT_WIDTH]) o_ovf[k] <= 1'b1;
`ifdef MATCH_STAT_SATURATE_EN
          cnt[k] <= sum[k][CNT_WIDTH] ? '1 : sum[k][CNT_WIDTH-1:0];
`else
          cnt[k] <= sum[k][CNT_WIDTH-1:0];
`endif
        end
      end
    end
  end

  assign o_match_count  = cnt[0];
  assign o_pass_count   = cnt[1];
  assign o_filter_count = cnt[2];

endmodule

// File: tb/tb_match_stat_counter.sv
// Directed bench for match_stat_counter; a second instance preloaded near the top exercises overflow.
module tb_match_stat_counter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  mv = '0;
  logic [3:0]  pv = '0;
  logic [3:0]  fv = '0;

  logic [31:0] m_cnt, p_cnt, f_cnt;
  logic [2:0]  ovf;
  logic        clearing;
  logic [31:0] om_cnt, op_cnt, of_cnt;
  logic [2:0]  o_ovf2;
  logic        o_clearing2;

  int checks = 0;
  int failures = 0;

`ifdef MATCH_STAT_SATURATE_EN
  localparam logic [31:0] OVF_A = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_B = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_A = 32'h0000_0001;
  localparam logic [31:0] OVF_B = 32'h0000_0002;
`endif

  match_stat_counter #(.LANES(4), .CNT_WIDTH(32)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid),
    .i_match_vec(mv), .i_pass_vec(pv), .i_filter_vec(fv),
    .i_counter_reset(clr),
    .o_match_count(m_cnt), .o_pass_count(p_cnt), .o_filter_count(f_cnt),
    .o_ovf(ovf), .o_clearing(clearing)
  );

  match_stat_counter #(.LANES(4), .CNT_WIDTH(32), .RST_COUNT(32'hFFFF_FFFE)) dut_ovf (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid),
    .i_match_vec(mv), .i_pass_vec(pv), .i_filter_vec(fv),
    .i_counter_reset(clr),
    .o_match_count(om_cnt), .o_pass_count(op_cnt), .o_filter_count(of_cnt),
    .o_ovf(o_ovf2), .o_clearing(o_clearing2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    valid = 1'b0;
    mv = '0;
    pv = '0;
    fv = '0;
  endtask

  initial begin
    tick(2);
    check("rst_match", m_cnt, 32'd0);
    check("rst_pass", p_cnt, 32'd0);
    check("rst_filter", f_cnt, 32'd0);
    check("rst_ovf", {29'd0, ovf}, 32'd0);
    check("rst_clearing", {31'd0, clearing}, 32'd0);
    check("rst_preload", om_cnt, 32'hFFFF_FFFE);
    rstn = 1'b1;
    tick(1);

    // 3 match events; overflow instance crosses 2^32
    valid = 1'b1; mv = 4'b1011;
    tick(1);
    idle();
    tick(1);
    check("lat_match_early", m_cnt, 32'd0);
    tick(1);
    check("t1_match", m_cnt, 32'd3);
    check("t1_pass", p_cnt, 32'd0);
    check("t1_filter", f_cnt, 32'd0);
    check("t1_ovf", {29'd0, ovf}, 32'd0);
    check("t3_ovf_match", om_cnt, OVF_A);
    check("t3_ovf_flag", {29'd0, o_ovf2}, 32'd1);
    check("t3_ovf_pass", op_cnt, 32'hFFFF_FFFE);

    valid = 1'b1; mv = 4'b0001;
    tick(1);
    idle();
    tick(2);
    check("t3_match_plus1", m_cnt, 32'd4);
    check("t3_ovf_after", om_cnt, OVF_B);
    check("t3_ovf_sticky", {29'd0, o_ovf2}, 32'd1);

    // invalid cycles contribute nothing
    valid = 1'b0; mv = 4'b1111; pv = 4'b1111; fv = 4'b1111;
    tick(10);
    idle();
    tick(3);
    check("t2_match", m_cnt, 32'd4);
    check("t2_pass", p_cnt, 32'd0);
    check("t2_filter", f_cnt, 32'd0);

    // clear coincident with pass events, release cycle events counted
    clr = 1'b1; valid = 1'b1; pv = 4'b1111;
    tick(1);
    check("t4_match_clr", m_cnt, 32'd0);
    check("t4_ovf_clr", {29'd0, o_ovf2}, 32'd0);
    check("t4_ovfcnt_clr", om_cnt, 32'd0);
    check("t4_clearing0", {31'd0, clearing}, 32'd1);
    clr = 1'b0; valid = 1'b1; pv = 4'b0011;
    tick(1);
    check("t4_clearing1", {31'd0, clearing}, 32'd1);
    idle();
    tick(1);
    check("t4_clearing2", {31'd0, clearing}, 32'd1);
    tick(1);
    check("t4_clearing3", {31'd0, clearing}, 32'd0);
    check("t4_pass_release", p_cnt, 32'd2);

    // events in S1/S2 flushed by clear
    valid = 1'b1; mv = 4'b1111;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    idle();
    tick(2);
    check("t5_match_flush", m_cnt, 32'd0);
    check("t5_pass_flush", p_cnt, 32'd0);
    tick(2);
    check("t5_match_settled", m_cnt, 32'd0);

    // async reset mid-stream
    valid = 1'b1; fv = 4'b1111;
    tick(3);
    check("t6_filter_pre", f_cnt, 32'd4);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_filter", f_cnt, 32'd0);
    check("t6_async_match", m_cnt, 32'd0);
    check("t6_async_pass", p_cnt, 32'd0);
    check("t6_async_ovf", {29'd0, ovf}, 32'd0);
    check("t6_async_clearing", {31'd0, clearing}, 32'd0);
    idle();
    tick(1);
    rstn = 1'b1;
    valid = 1'b1; fv = 4'b0110;
    tick(2);
    idle();
    tick(2);
    check("t6_filter_after", f_cnt, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
